// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit mid-point qualification, then one sample per bit period.
// o_data[0] holds the first data bit on the line; o_dbg_state exposes the FSM state.
module uart_receiver #(
    parameter int CYCLES_PER_SAMPLE = 10416
) (
    input  logic       clk,
    input  logic       r_reset,
    input  logic       i_rx,
    output logic [0:7] o_data,
    output logic       o_valid,
    output logic       o_frame_error,
    output logic       o_busy,
    output logic [2:0] o_dbg_state
);

    localparam int          HALF_SAMPLE = CYCLES_PER_SAMPLE / 2;
    localparam logic [15:0] LAST_BIT    = 16'(CYCLES_PER_SAMPLE - 1);
    localparam logic [15:0] LAST_HALF   = 16'(HALF_SAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_cnt;
    logic [3:0]  r_idx;
    logic [0:7]  r_shreg;
    logic        w_rx_s;

    assign w_rx_s      = r_sync2;
    assign o_dbg_state = r_state;

    // Handshake: none. o_valid is a single-cycle strobe with no ready; the consumer
    // must take o_data in that cycle, and o_data then holds until the next strobe.
    always_ff @(posedge clk) begin
        if (r_reset) begin
            r_state       <= IDLE;
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shreg       <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            r_sync1       <= i_rx;
            r_sync2       <= r_sync1;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                START: begin
                    // A low that does not survive to mid-bit is a glitch, not a start bit.
                    if (r_cnt == LAST_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= IDLE;
                            o_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == LAST_BIT) begin
                        r_shreg[r_idx[2:0]] <= w_rx_s;
                        r_cnt               <= '0;
                        r_idx               <= r_idx + 4'd1;
                        if (r_idx == 4'd7)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == LAST_BIT) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            o_data  <= r_shreg;
                            o_valid <= 1'b1;
                            r_state <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            o_frame_error <= 1'b1;
                            r_state       <= RECOVER;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RECOVER: begin
                    // Wait out a break so a held-low line cannot look like a new start bit.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks per bit: frame table, glitch, break, reset
// and jitter sequences, with a scoreboard queue checked on every o_valid strobe.
module tb_uart_receiver;

    localparam int         CPS       = 16;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic       clk = 1'b0;
    logic       r_reset;
    logic       i_rx;
    logic [0:7] o_data;
    logic       o_valid;
    logic       o_frame_error;
    logic       o_busy;
    logic [2:0] o_dbg_state;

    uart_receiver #(.CYCLES_PER_SAMPLE(CPS)) dut (
        .clk           (clk),
        .r_reset       (r_reset),
        .i_rx          (i_rx),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_frame_error (o_frame_error),
        .o_busy        (o_busy),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [0:7] model_data;
    logic       mon_en = 1'b0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         exp_ferr = 0;
    int         n_pushed = 0;
    int         first_valid_cyc = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid) begin
                n_valid++;
                if (n_valid == 1) first_valid_cyc = cyc;
                check("valid_ferr_exclusive", {31'd0, o_frame_error}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got data %0h with empty expected queue", o_data);
                end else begin
                    model_data = exp_q.pop_front();
                end
            end
            if (o_frame_error) n_ferr++;
            check("o_data_hold", {24'd0, o_data}, {24'd0, model_data});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // jit != 0 alternates bit periods of CPS+2 and CPS-2, starting with the start bit.
    task automatic send_frame(input logic [0:7] d, input logic stop, input int jit);
        int per;
        for (int k = 0; k < 10; k++) begin
            per = CPS + ((jit != 0) ? ((k % 2 == 0) ? 2 : -2) : 0);
            if (k == 0) begin
                i_rx = 1'b0;
            end else if (k < 9) begin
                i_rx = d[k-1];
            end else begin
                i_rx = stop;
                if (stop) begin
                    exp_q.push_back(d);
                    n_pushed++;
                end else begin
                    exp_ferr++;
                end
            end
            repeat (per) @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [0:7] data;
        logic       stop;
        int         gap;
    } vec_t;

    vec_t       vecs[6];
    logic [0:7] tmp;
    int         t0;
    int         lat;
    int         v_before;

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 30};
        vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 30};
        for (int i = 3; i < 6; i++) begin
            vecs[i].data = 8'($urandom_range(0, 255));
            vecs[i].stop = 1'b1;
            vecs[i].gap  = $urandom_range(0, 20);
        end

        // Reset state
        r_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_data", {24'd0, o_data}, 32'd0);
        check("reset_o_valid", {31'd0, o_valid}, 32'd0);
        check("reset_o_ferr", {31'd0, o_frame_error}, 32'd0);
        check("reset_o_busy", {31'd0, o_busy}, 32'd0);
        check("reset_state", {29'd0, o_dbg_state}, {29'd0, S_IDLE});
        r_reset    = 1'b0;
        model_data = '0;
        mon_en     = 1'b1;
        idle(10);

        // Frame table (A5, then 00 and FF back to back, then random bytes)
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, 0);
            idle(vecs[i].gap);
        end
        idle(20);
        lat = first_valid_cyc - t0;
        check("latency_window", {31'd0, (lat >= 155 && lat <= 157)}, 32'd1);
        check("table_valid_count", n_valid, 6);
        check("table_ferr_count", n_ferr, 0);
        tmp = vecs[5].data;
        check("table_last_data", {24'd0, o_data}, {24'd0, tmp});

        // Three-cycle glitch while idle
        v_before = n_valid;
        i_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rx = 1'b1;
        idle(1);
        check("glitch_busy_high", {31'd0, o_busy}, 32'd1);
        check("glitch_state_start", {29'd0, o_dbg_state}, {29'd0, S_START});
        idle(20);
        check("glitch_busy_low", {31'd0, o_busy}, 32'd0);
        check("glitch_state_idle", {29'd0, o_dbg_state}, {29'd0, S_IDLE});
        check("glitch_no_valid", n_valid, v_before);
        check("glitch_no_ferr", n_ferr, 0);

        // Bad stop bit followed by a break, then a good frame
        send_frame(8'h3C, 1'b0, 0);
        repeat (40) @(posedge clk);
        #1;
        check("break_ferr_count", n_ferr, 1);
        check("break_state_recover", {29'd0, o_dbg_state}, {29'd0, S_RECOVER});
        check("break_busy", {31'd0, o_busy}, 32'd1);
        check("break_data_kept", {24'd0, o_data}, {24'd0, tmp});
        idle(6);
        check("break_state_idle", {29'd0, o_dbg_state}, {29'd0, S_IDLE});
        send_frame(8'h81, 1'b1, 0);
        idle(20);
        tmp = 8'h81;
        check("after_break_data", {24'd0, o_data}, {24'd0, tmp});

        // Reset during data bit 4
        v_before = n_valid;
        tmp = 8'h96;
        i_rx = 1'b0;
        repeat (CPS) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            i_rx = tmp[k];
            repeat (CPS) @(posedge clk);
            #1;
        end
        i_rx = tmp[4];
        repeat (CPS / 2) @(posedge clk);
        #1;
        check("midframe_busy", {31'd0, o_busy}, 32'd1);
        check("midframe_state_data", {29'd0, o_dbg_state}, {29'd0, S_DATA});
        r_reset = 1'b1;
        @(posedge clk);
        #1;
        r_reset    = 1'b0;
        i_rx       = 1'b1;
        model_data = '0;
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_data_zero", {24'd0, o_data}, 32'd0);
        check("abort_state_idle", {29'd0, o_dbg_state}, {29'd0, S_IDLE});
        idle(40);
        check("abort_no_valid", n_valid, v_before);
        send_frame(8'h5A, 1'b1, 0);
        idle(20);
        tmp = 8'h5A;
        check("after_reset_data", {24'd0, o_data}, {24'd0, tmp});

        // Alternating +/-2 cycle bit-period jitter
        send_frame(8'hC3, 1'b1, 1);
        idle(20);
        tmp = 8'hC3;
        check("jitter_data", {24'd0, o_data}, {24'd0, tmp});

        // Final scoreboard accounting
        check("queue_drained", exp_q.size(), 0);
        check("total_valid", n_valid, n_pushed);
        check("total_ferr", n_ferr, exp_ferr);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CYCLES_PER_SAMPLE, default 10416, SHALL be the clk cycles per bit (9600 baud at 100 MHz); legal range 4..65535.
REQ-002 Derived constant HALF_SAMPLE = CYCLES_PER_SAMPLE/2 (integer division) SHALL set the start-bit mid-point.
REQ-003 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-004 r_reset  input  1  reset, synchronous, active-high.
REQ-005 i_rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 o_data  output  [0:7]  last correctly framed byte; o_data[0] is the first data bit received.
REQ-007 o_valid  output  1  one-cycle pulse: o_data updated with a new good byte.
REQ-008 o_frame_error  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
REQ-009 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer; rx_s denotes its output; all decisions SHALL use rx_s only.
REQ-011 State machine SHALL have states IDLE, START, DATA, STOP, RECOVER.
REQ-012 Counters: 16-bit cycle counter (cnt), 4-bit bit index (idx), 8-bit shift register (shreg).
REQ-013 IDLE: rx_s==0 -> START, cnt=0; else remain IDLE.
REQ-014 START: cnt increments each cycle; at cnt==HALF_SAMPLE-1, rx_s==0 -> DATA with cnt=0, idx=0; rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: cnt increments; at cnt==CYCLES_PER_SAMPLE-1, rx_s SHALL be stored into shreg[idx], cnt=0, idx+1; after storing idx==7 -> STOP.
REQ-016 STOP: cnt increments; at cnt==CYCLES_PER_SAMPLE-1, sample rx_s and set cnt=0.
REQ-017 Stop sample 1: next cycle o_data=shreg, o_valid=1, state IDLE.
REQ-018 Stop sample 0: next cycle o_frame_error=1, o_data unchanged, state RECOVER.
REQ-019 RECOVER: remain until rx_s==1, then IDLE; prevents a held-low line (break) re-triggering a frame.
REQ-020 o_valid and o_frame_error SHALL never both be high; each SHALL be high for exactly one cycle per frame.
REQ-021 o_data SHALL hold its value between o_valid pulses; it SHALL change on no other event.
REQ-022 No backpressure: consumer SHALL capture o_data on o_valid; a following frame overwrites it.
REQ-023 Back-to-back frames: a start edge arriving immediately after the stop mid-sample SHALL be accepted (IDLE re-arms same cycle as o_valid).
REQ-024 Latency: o_valid asserts HALF_SAMPLE + 9*CYCLES_PER_SAMPLE + 4 cycles (+/-1 sync uncertainty) after the i_rx falling edge.
REQ-025 cnt and idx SHALL never exceed CYCLES_PER_SAMPLE-1 and 8 respectively; no wrap-around of the 16-bit cnt is permitted.

Reset
REQ-026 r_reset==1 at a posedge SHALL set state IDLE, cnt=0, idx=0, shreg=0, o_data=0, o_valid=0, o_frame_error=0, o_busy=0, both synchronizer flops=1.
REQ-027 Reset mid-frame SHALL abort the frame with no o_valid or o_frame_error pulse; reception resumes on the next falling edge after reset deasserts.
REQ-028 Reset SHALL take priority over every state transition in the same cycle.

Verification (bench uses CYCLES_PER_SAMPLE=16)
REQ-029 Loopback from uart_transmitter sending 8'hA5 (bits [0:7]=1,0,1,0,0,1,0,1) -> single o_valid, o_data=8'hA5, o_frame_error never high.
REQ-030 Two back-to-back frames 8'h00 then 8'hFF, no idle gap -> two o_valid pulses, o_data=8'h00 then 8'hFF.
REQ-031 i_rx low for 3 cycles while idle -> START then IDLE, o_busy falls, no o_valid/o_frame_error.
REQ-032 Frame 8'h3C with stop bit driven 0, line held low 40 further cycles -> one o_frame_error, o_data keeps prior value, state RECOVER until i_rx high, then next good frame 8'h81 -> o_valid, o_data=8'h81.
REQ-033 r_reset pulsed during data bit 4 of a frame -> o_busy=0 next cycle, no output pulses, o_data=0; subsequent frame 8'h5A received correctly.
REQ-034 Bit-timing jitter: each bit period stretched/shrunk by 2 cycles on a frame 8'hC3 -> o_valid, o_data=8'hC3.
